// File: rtl/reset_seq.sv
`timescale 1ns/1ps
// Purpose : staged reset sequencer; holds N_STAGES reset outputs until reset release and
//           PLL lock, waits DELAY_CYCLES, then releases one stage every STAGE_GAP cycles.
// Latency : res[k] falls DELAY_CYCLES + k*STAGE_GAP edges after the HOLD->COUNT edge (T0);
//           T0 follows SYNC_STAGES+1 edges after release/lock. No backpressure; async reset
//           forces all outputs instantly.
// Ports   : clock        - single clock, rising edge
//           async_res_n  - async active-low reset (async assert, synchronised release)
//           pll_lock     - async level, high when the clock source is stable
//           sw_res_req   - synchronous single-cycle request to replay the sequence
//           res          - active-high per-stage reset, bit 0 releases first
//           ready        - high only when every res bit is low
//           state        - FSM encoding HOLD=0, COUNT=1, STAGE=2, RUN=3
module reset_seq #(
  parameter logic [31:0] DELAY_CYCLES = 32'd8_000_000,
  parameter int          N_STAGES     = 4,
  parameter int          STAGE_GAP    = 1024,
  parameter int          CNT_W        = 32,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                clock,
  input  logic                async_res_n,
  input  logic                pll_lock,
  input  logic                sw_res_req,
  output logic [N_STAGES-1:0] res,
  output logic                ready,
  output logic [1:0]          state
);

  // A zero delay behaves as one cycle so the counter load never underflows.
  localparam logic [CNT_W-1:0] DLY_LOAD =
    (DELAY_CYCLES == 32'd0) ? '0 : CNT_W'(DELAY_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    STAGE = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                 fsm;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] rel_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rel_ok;
  logic                   lock_ok;
  logic                   abort;
  logic [N_STAGES-1:0]    res_next;

  // Both synchronisers are cleared by the async reset so a lock seen before
  // reset never leaks into the next sequence.
  always_ff @(posedge clock or negedge async_res_n) begin
    if (!async_res_n) begin
      rel_sync  <= '0;
      lock_sync <= '0;
    end else begin
      rel_sync  <= {rel_sync[SYNC_STAGES-2:0], 1'b1};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign rel_ok  = rel_sync[SYNC_STAGES-1];
  assign lock_ok = lock_sync[SYNC_STAGES-1];

  // Lock loss and a software request share one path, so a coincident pair
  // produces exactly one HOLD entry.
  assign abort = !lock_ok || sw_res_req;

  // Released bits are shifted out from the bottom; an all-zero result means
  // the last stage is being released on this edge.
  assign res_next = res << 1;

  assign state = fsm;

  always_ff @(posedge clock or negedge async_res_n) begin
    if (!async_res_n) begin
      fsm   <= HOLD;
      res   <= '1;
      ready <= 1'b0;
      cnt   <= DLY_LOAD;
    end else begin
      case (fsm)
        HOLD: begin
          res   <= '1;
          ready <= 1'b0;
          cnt   <= DLY_LOAD;
          if (rel_ok && lock_ok) fsm <= COUNT;
        end
        default: begin
          if (abort) begin
            fsm   <= HOLD;
            res   <= '1;
            ready <= 1'b0;
            cnt   <= DLY_LOAD;
          end else if (fsm != RUN) begin
            // COUNT and STAGE share the same "count down, release one bit" step.
            if (cnt == '0) begin
              res <= res_next;
              cnt <= GAP_LOAD;
              if (res_next == '0) begin
                fsm   <= RUN;
                ready <= 1'b1;
              end else begin
                fsm <= STAGE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
`timescale 1ns/1ps
// Purpose : directed bench for reset_seq with DELAY_CYCLES=10, N_STAGES=4, STAGE_GAP=3.
// Latency : T0 expected 3 edges after release/lock; stages fall at T0+10/13/16/19.
// Backpressure : none; inputs driven at falling edges, outputs sampled at falling edges.
module tb_reset_seq;

  logic       clock;
  logic       async_res_n;
  logic       pll_lock;
  logic       sw_res_req;
  logic [3:0] res;
  logic       ready;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  reset_seq #(
    .DELAY_CYCLES(32'd10),
    .N_STAGES    (4),
    .STAGE_GAP   (3),
    .CNT_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clock      (clock),
    .async_res_n(async_res_n),
    .pll_lock   (pll_lock),
    .sw_res_req (sw_res_req),
    .res        (res),
    .ready      (ready),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {state, ready, res} k edges after T0 (hand-derived release schedule).
  function automatic logic [6:0] exp_vec(input int k);
    if (k < 10)      return {2'd1, 1'b0, 4'b1111};
    else if (k < 13) return {2'd2, 1'b0, 4'b1110};
    else if (k < 16) return {2'd2, 1'b0, 4'b1100};
    else if (k < 19) return {2'd2, 1'b0, 4'b1000};
    else             return {2'd3, 1'b1, 4'b0000};
  endfunction

  // Bounded wait for the HOLD->COUNT edge; reports edges taken.
  task automatic wait_t0(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < 50) begin
      @(negedge clock);
      edges++;
      if (state == 2'd1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    async_res_n = 1'b0;
    pll_lock    = 1'b1;
    sw_res_req  = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({state, ready, res} !== 7'b00_0_1111) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", {state, ready, res}, 7'b00_0_1111);
    end
    checks++;
    if (dut.cnt !== 8'd9) begin
      errors++;
      $display("FAIL reset_cnt got=%0d want=9", dut.cnt);
    end
  endtask

  task automatic test_normal();
    int  edges;
    bit  ok;
    async_res_n = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok || edges != 3) begin
      errors++;
      $display("FAIL normal_t0 got_edges=%0d ok=%0d want_edges=3", edges, ok);
    end
    for (int k = 0; k <= 21; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL normal_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_late_lock();
    int  edges;
    bit  ok;
    async_res_n = 1'b0;
    pll_lock    = 1'b0;
    @(negedge clock);
    async_res_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({state, res} !== 6'b00_1111) begin
        errors++;
        $display("FAIL late_lock_hold i=%0d got=%b want=%b", i, {state, res}, 6'b00_1111);
      end
    end
    pll_lock = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok || edges != 3) begin
      errors++;
      $display("FAIL late_lock_t0 got_edges=%0d ok=%0d want_edges=3", edges, ok);
    end
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL late_lock_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_lock_loss();
    int  edges;
    bit  ok;
    async_res_n = 1'b0;
    @(negedge clock);
    async_res_n = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lock_loss_t0 got_edges=%0d want=found", edges);
    end
    repeat (14) @(negedge clock);
    checks++;
    if (res !== 4'b1100) begin
      errors++;
      $display("FAIL lock_loss_pre got=%b want=1100", res);
    end
    pll_lock = 1'b0;
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < 10) begin
      @(negedge clock);
      edges++;
      if (state == 2'd0) ok = 1'b1;
    end
    checks++;
    if (!ok || edges != 3 || res !== 4'b1111 || ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_loss_hold edges=%0d ok=%0d res=%b ready=%b want edges=3 res=1111 ready=0",
               edges, ok, res, ready);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({state, res} !== 6'b00_1111) begin
      errors++;
      $display("FAIL lock_loss_stay got=%b want=%b", {state, res}, 6'b00_1111);
    end
    pll_lock = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok || edges != 3) begin
      errors++;
      $display("FAIL relock_t0 got_edges=%0d ok=%0d want_edges=3", edges, ok);
    end
    for (int k = 0; k <= 21; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL relock_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  // Entered in RUN.
  task automatic test_sw_req();
    sw_res_req = 1'b1;
    @(negedge clock);
    sw_res_req = 1'b0;
    checks++;
    if ({state, ready, res} !== 7'b00_0_1111 || dut.cnt !== 8'd9) begin
      errors++;
      $display("FAIL sw_req_hold got=%b cnt=%0d want=%b cnt=9", {state, ready, res}, dut.cnt,
               7'b00_0_1111);
    end
    @(negedge clock);
    for (int k = 0; k <= 21; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL sw_req_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  // Entered in RUN.
  task automatic test_async_mid();
    int  edges;
    bit  ok;
    sw_res_req = 1'b1;
    @(negedge clock);
    sw_res_req = 1'b0;
    wait_t0(edges, ok);
    repeat (12) @(negedge clock);
    checks++;
    if (res !== 4'b1110) begin
      errors++;
      $display("FAIL async_mid_pre got=%b want=1110", res);
    end
    #2;
    async_res_n = 1'b0;
    #1;
    checks++;
    if ({state, ready, res} !== 7'b00_0_1111) begin
      errors++;
      $display("FAIL async_mid_clear got=%b want=%b", {state, ready, res}, 7'b00_0_1111);
    end
    @(negedge clock);
    async_res_n = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok || edges != 3) begin
      errors++;
      $display("FAIL async_mid_t0 got_edges=%0d ok=%0d want_edges=3", edges, ok);
    end
    for (int k = 0; k <= 21; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL async_mid_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  // Entered in RUN. Lock loss reaches the FSM on the third edge; sw_res_req is
  // timed to land on that same edge.
  task automatic test_sw_and_lock();
    int  edges;
    bit  ok;
    pll_lock = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL both_pre got_state=%0d want=3", state);
    end
    sw_res_req = 1'b1;
    @(negedge clock);
    sw_res_req = 1'b0;
    checks++;
    if ({state, ready, res} !== 7'b00_0_1111 || dut.cnt !== 8'd9) begin
      errors++;
      $display("FAIL both_hold got=%b cnt=%0d want=%b cnt=9", {state, ready, res}, dut.cnt,
               7'b00_0_1111);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (state !== 2'd0 || dut.cnt !== 8'd9) begin
      errors++;
      $display("FAIL both_stay state=%0d cnt=%0d want state=0 cnt=9", state, dut.cnt);
    end
    pll_lock = 1'b1;
    wait_t0(edges, ok);
    checks++;
    if (!ok || edges != 3 || dut.cnt !== 8'd9) begin
      errors++;
      $display("FAIL both_t0 edges=%0d ok=%0d cnt=%0d want edges=3 cnt=9", edges, ok, dut.cnt);
    end
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if ({state, ready, res} !== exp_vec(k)) begin
        errors++;
        $display("FAIL both_seq k=%0d got=%b want=%b", k, {state, ready, res}, exp_vec(k));
      end
      @(negedge clock);
    end
  endtask

  initial begin
    async_res_n = 1'b0;
    pll_lock    = 1'b1;
    sw_res_req  = 1'b0;
    @(negedge clock);
    test_reset();
    test_normal();
    test_late_lock();
    test_lock_loss();
    test_sw_req();
    test_async_mid();
    test_sw_and_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
